// File: rtl/genius_pkg.sv
// genius_pkg
//   Shared definitions for the genius game datapath: the 2-bit symbol codes
//   used by the input stage, the sequence storage and the game FSM; the
//   input-capture FSM state encoding; and a one-hot-to-symbol encoder.
package genius_pkg;

  localparam logic [1:0] SYM_ZERO = 2'b00;
  localparam logic [1:0] SYM_ONE  = 2'b01;
  localparam logic [1:0] SYM_TWO  = 2'b10;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    HELD        = 2'd2,
    DEB_RELEASE = 2'd3
  } cap_state_t;

  // True when exactly one of the three button bits is set.
  function automatic logic is_onehot3(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

  // Maps a one-hot pressed vector to its symbol; callers only use it on
  // one-hot inputs, anything else falls back to SYM_ZERO.
  function automatic logic [1:0] encode_onehot(input logic [2:0] v);
    case (v)
      3'b010:  return SYM_ONE;
      3'b100:  return SYM_TWO;
      default: return SYM_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/genius_sync2.sv
// genius_sync2
//   Two-flop synchronizer for asynchronous level inputs.
//   Ports:
//     clock      in  rising-edge clock
//     reset      in  asynchronous active-high reset
//     rst_level  in  [WIDTH-1:0] value both stages take during reset
//     d          in  [WIDTH-1:0] asynchronous inputs
//     q          out [WIDTH-1:0] synchronized outputs
module genius_sync2 #(
  parameter int WIDTH = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] rst_level,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour; blocking here would
  // collapse the two stages into one.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta <= rst_level;
      q    <= rst_level;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/genius_input_capture.sv
// genius_input_capture
//   Player-input stage for the genius game: synchronizes and debounces the
//   three buttons, reports each qualified press as a symbol with a one-cycle
//   valid pulse, flags simultaneous presses, and signals a response timeout.
//   Ports:
//     clock      in   rising-edge clock
//     reset      in   asynchronous active-high reset
//     bt0..bt2   in   raw asynchronous buttons
//     en         in   high while the game FSM accepts input
//     sym        out  [1:0] symbol of last qualified press (held between pulses)
//     sym_valid  out  one-cycle pulse, sym valid in the same cycle
//     multi_err  out  one-cycle pulse, more than one button qualified together
//     timeout    out  one-cycle pulse, no press within TIMEOUT_CYCLES while en=1
//     busy       out  high outside IDLE
module genius_input_capture
  import genius_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TIMEOUT_CYCLES  = 250000000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       bt0,
  input  logic       bt1,
  input  logic       bt2,
  input  logic       en,
  output logic [1:0] sym,
  output logic       sym_valid,
  output logic       multi_err,
  output logic       timeout,
  output logic       busy
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TCNT_FULL = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    REL_LEVEL = {3{BTN_ACTIVE_LOW}};

  logic [2:0]    sync_q;
  logic [2:0]    p;
  cap_state_t    state, state_next;
  logic [DW-1:0] dcnt, dcnt_next;
  logic [2:0]    cand, cand_next;
  logic          fire_sym, fire_multi;
  logic [TW-1:0] tcnt;

  genius_sync2 #(.WIDTH(3)) u_sync (
    .clock     (clock),
    .reset     (reset),
    .rst_level (REL_LEVEL),
    .d         ({bt2, bt1, bt0}),
    .q         (sync_q)
  );

  // Normalising register: p is 1 = pressed. This stage also sets the
  // press-to-pulse latency at DEBOUNCE_CYCLES+2 edges.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) p <= '0;
    else       p <= BTN_ACTIVE_LOW ? ~sync_q : sync_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= DEB_RELEASE;
      dcnt  <= '0;
      cand  <= '0;
    end else begin
      state <= state_next;
      dcnt  <= dcnt_next;
      cand  <= cand_next;
    end
  end

  // NOTE: every signal driven here gets a default before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    dcnt_next  = dcnt;
    cand_next  = cand;
    fire_sym   = 1'b0;
    fire_multi = 1'b0;
    case (state)
      IDLE: begin
        if (p != 3'b000) begin
          state_next = DEB_PRESS;
          cand_next  = p;
          dcnt_next  = DW'(1);
        end
      end
      DEB_PRESS: begin
        if (p != cand) begin
          state_next = IDLE;
          dcnt_next  = '0;
        end else if (dcnt == DCNT_LAST) begin
          state_next = HELD;
          dcnt_next  = '0;
          if (en) begin
            fire_sym   = is_onehot3(cand);
            fire_multi = !is_onehot3(cand);
          end
        end else begin
          dcnt_next = dcnt + DW'(1);
        end
      end
      HELD: begin
        // Changes between nonzero patterns are ignored until full release.
        if (p == 3'b000) begin
          state_next = DEB_RELEASE;
          dcnt_next  = DW'(1);
        end
      end
      DEB_RELEASE: begin
        // A renewed press wins over an expiring release count.
        if (p != 3'b000) begin
          state_next = HELD;
          dcnt_next  = '0;
        end else if (dcnt == DCNT_LAST) begin
          state_next = IDLE;
          dcnt_next  = '0;
        end else begin
          dcnt_next = dcnt + DW'(1);
        end
      end
      default: begin
        state_next = DEB_RELEASE;
        dcnt_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sym       <= SYM_ZERO;
      sym_valid <= 1'b0;
      multi_err <= 1'b0;
    end else begin
      sym_valid <= fire_sym;
      multi_err <= fire_multi;
      if (fire_sym) sym <= encode_onehot(cand);
    end
  end

  // Timeout counter saturates at TIMEOUT_CYCLES so the pulse fires once
  // per enable window; a qualified press or en=0 rearms it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tcnt    <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (!en || fire_sym || fire_multi) begin
        tcnt <= '0;
      end else if ((TIMEOUT_CYCLES > 0) && (state == IDLE) && (tcnt != TCNT_FULL)) begin
        tcnt <= tcnt + TW'(1);
        if (tcnt == TCNT_LAST) timeout <= 1'b1;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
